// File: rtl/ac_group_acc_bank.sv
// ac_group_acc_bank: four saturating per-group accumulators feeding an in-order {group,sum} output FIFO
module ac_group_acc_bank #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid_in,
  output logic              in_ready,
  input  logic [1:0]        sel_grp,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [1:0]        out_grp,
  output logic [3:0]        grp_busy,
  output logic              overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [ACC_W-1:0] acc [4];
  logic [ACC_W+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [ACC_W-1:0] hold_data;
  logic [1:0]       hold_grp;
  logic [ACC_W:0]   wide;
  logic [ACC_W-1:0] sat_sum;
  logic             clamp, xfer, push, pop;
  always_comb begin
    in_ready  = (count != CW'(FIFO_DEPTH)) && !clear;
    xfer      = valid_in && in_ready;
    push      = xfer && last_in;
    out_valid = count != '0;
    pop       = out_valid && out_ready && !clear;
    wide      = {acc[sel_grp][ACC_W-1], acc[sel_grp]} + {{(ACC_W+1-DATA_W){data_in[DATA_W-1]}}, data_in};
    clamp     = wide[ACC_W] != wide[ACC_W-1];
    sat_sum   = clamp ? {wide[ACC_W], {(ACC_W-1){!wide[ACC_W]}}} : wide[ACC_W-1:0];
    out_data  = out_valid ? mem[rd_ptr][ACC_W-1:0] : hold_data;
    out_grp   = out_valid ? mem[rd_ptr][ACC_W+1:ACC_W] : hold_grp;
  end
  // when empty the outputs show the last popped entry, not whatever stale slot rd_ptr lands on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_data <= '0;
      hold_grp  <= '0;
      grp_busy  <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      grp_busy <= '0;
      overflow <= 1'b0;
    end else begin
      if (xfer) begin
        acc[sel_grp]      <= last_in ? '0 : sat_sum;
        grp_busy[sel_grp] <= !last_in;
        overflow          <= overflow | clamp;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_data <= out_data;
        hold_grp  <= out_grp;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sel_grp, sat_sum};
  end
endmodule
